// File: rtl/cmp_max_pkg.sv
// cmp_max_pkg: shared extremes, better-than compare and entry type for the n-way max/min search.
// Entries are carried at the widest supported width; modules narrow them to their own parameters.
package cmp_max_pkg;
  localparam int MAX_W = 64;
  typedef logic signed [MAX_W-1:0] wide_t;
  typedef struct packed {
    wide_t            val;
    logic [MAX_W-1:0] loc;
    logic             hit;
  } entry_t;
  function automatic wide_t most_neg(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction
  function automatic wide_t most_pos(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction
  function automatic logic better(input wide_t a, input wide_t b, input logic mode_min);
    return mode_min ? (a < b) : (a > b);
  endfunction
  function automatic entry_t empty_entry(input int w, input logic mode_min);
    return entry_t'{val: mode_min ? most_pos(w) : most_neg(w), loc: '0, hit: 1'b0};
  endfunction
  // b must be strictly better to displace a, so ties always keep a (the earlier candidate).
  function automatic entry_t pick(input entry_t a, input entry_t b, input logic mode_min);
    return (b.hit && (!a.hit || better(b.val, a.val, mode_min))) ? b : a;
  endfunction
endpackage

// File: rtl/cmp_max_lane_tree.sv
// cmp_max_lane_tree: combinational reduction of one beat's valid lanes to the best (value, location, hit).
module cmp_max_lane_tree
  import cmp_max_pkg::*;
#(
  parameter int CMP_WIDTH      = 16,
  parameter int LOCATION_WIDTH = 32,
  parameter int LANES          = 4,
  parameter bit MODE_MIN       = 1'b0
) (
  input  logic [LANES-1:0]           lane_valid,
  input  logic [LANES*CMP_WIDTH-1:0] num,
  input  logic [LOCATION_WIDTH-1:0]  loc_base,
  output logic [CMP_WIDTH-1:0]       best_val,
  output logic [LOCATION_WIDTH-1:0]  best_loc,
  output logic                       best_hit
);
  // Heap layout: leaves at LANES..2*LANES-1; node k merges 2k (lower lanes) with 2k+1.
  function automatic void reduce(
    input  logic [LANES-1:0]           v,
    input  logic [LANES*CMP_WIDTH-1:0] n,
    input  logic [LOCATION_WIDTH-1:0]  base,
    output logic [CMP_WIDTH-1:0]       r_val,
    output logic [LOCATION_WIDTH-1:0]  r_loc,
    output logic                       r_hit
  );
    entry_t node [1:2*LANES-1];
    for (int i = 0; i < LANES; i++) begin
      if (v[i])
        node[LANES+i] = entry_t'{val: wide_t'($signed(n[i*CMP_WIDTH +: CMP_WIDTH])),
                                 loc: MAX_W'(base + LOCATION_WIDTH'(i)), hit: 1'b1};
      else
        node[LANES+i] = empty_entry(CMP_WIDTH, MODE_MIN);
    end
    for (int k = LANES - 1; k >= 1; k--) node[k] = pick(node[2*k], node[2*k+1], MODE_MIN);
    r_val = node[1].val[CMP_WIDTH-1:0];
    r_loc = node[1].loc[LOCATION_WIDTH-1:0];
    r_hit = node[1].hit;
  endfunction
  always_comb reduce(lane_valid, num, loc_base, best_val, best_loc, best_hit);
endmodule

// File: rtl/cmp_max_nway.sv
// cmp_max_nway: multi-context pipelined max/min search; lane reduce, context merge, then result register.
module cmp_max_nway
  import cmp_max_pkg::*;
#(
  parameter int CMP_WIDTH      = 16,
  parameter int LOCATION_WIDTH = 32,
  parameter int LANES          = 4,
  parameter int CTX            = 6,
  parameter int MODE_MIN       = 0,
  localparam int CTX_W         = $clog2(CTX)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [CTX_W-1:0]           in_ctx,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [LANES-1:0]           in_lane_valid,
  input  logic [LANES*CMP_WIDTH-1:0] in_num,
  input  logic [LOCATION_WIDTH-1:0]  in_loc_base,
  output logic                       out_valid,
  output logic [CTX_W-1:0]           out_ctx,
  output logic [CMP_WIDTH-1:0]       out_max,
  output logic [LOCATION_WIDTH-1:0]  out_loc,
  output logic                       out_hit
);
  localparam bit MIN = (MODE_MIN != 0);
  typedef struct packed {
    logic [CMP_WIDTH-1:0]      val;
    logic [LOCATION_WIDTH-1:0] loc;
    logic                      hit;
  } ent_t;
  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [CTX_W-1:0] ctx;
    ent_t             e;
  } beat_t;
  typedef struct packed {
    logic             valid;
    logic [CTX_W-1:0] ctx;
    ent_t             e;
  } res_t;
  localparam ent_t EMPTY = '{val: CMP_WIDTH'(MIN ? most_pos(CMP_WIDTH) : most_neg(CMP_WIDTH)),
                             loc: '0, hit: 1'b0};
  function automatic entry_t widen(input ent_t x);
    return entry_t'{val: wide_t'($signed(x.val)), loc: MAX_W'(x.loc), hit: x.hit};
  endfunction
  function automatic ent_t merge(input ent_t st, input ent_t b, input logic first);
    entry_t m;
    m = pick(widen(st), widen(b), MIN);
    if (first) return b;
    return ent_t'{val: m.val[CMP_WIDTH-1:0], loc: m.loc[LOCATION_WIDTH-1:0], hit: m.hit};
  endfunction
  logic [CMP_WIDTH-1:0]      t_val;
  logic [LOCATION_WIDTH-1:0] t_loc;
  logic                      t_hit;
  beat_t s1_q, s1_d;
  res_t  s2_q, s2_d, out_q, out_d;
  ent_t  st_q [CTX];
  ent_t  st_d [CTX];
  ent_t  mrg;
  cmp_max_lane_tree #(
    .CMP_WIDTH(CMP_WIDTH), .LOCATION_WIDTH(LOCATION_WIDTH), .LANES(LANES), .MODE_MIN(MIN)
  ) u_tree (
    .lane_valid(in_lane_valid), .num(in_num), .loc_base(in_loc_base),
    .best_val(t_val), .best_loc(t_loc), .best_hit(t_hit)
  );
  // Store is written at the same edge stage 2 registers, so a following beat to the same context sees it.
  always_comb begin
    s1_d = '{valid: in_valid && (int'(in_ctx) < CTX) && !clear, first: in_first, last: in_last,
             ctx: in_ctx, e: '{val: t_val, loc: t_loc, hit: t_hit}};
    mrg = merge(st_q[s1_q.ctx], s1_q.e, s1_q.first);
    for (int c = 0; c < CTX; c++)
      st_d[c] = (clear || (s1_q.valid && s1_q.ctx == CTX_W'(c) && s1_q.last)) ? EMPTY :
                (s1_q.valid && s1_q.ctx == CTX_W'(c)) ? mrg : st_q[c];
    s2_d = '{valid: s1_q.valid && s1_q.last && !clear, ctx: s1_q.ctx, e: mrg};
    out_d = s2_q.valid ? s2_q : '{valid: 1'b0, ctx: out_q.ctx, e: out_q.e};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
      for (int c = 0; c < CTX; c++) st_q[c] <= EMPTY;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
      st_q  <= st_d;
    end
  end
  assign out_valid = out_q.valid;
  assign out_ctx   = out_q.ctx;
  assign out_max   = out_q.e.val;
  assign out_loc   = out_q.e.loc;
  assign out_hit   = out_q.e.hit;
endmodule

// File: tb/tb_cmp_max_nway.sv
// tb_cmp_max_nway: directed and random checks of cmp_max_nway against a per-context candidate-list model.
module tb_cmp_max_nway;
  localparam int CW = 16, LW = 32, LN = 4, CTX = 6, XW = $clog2(CTX);
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [XW-1:0] in_ctx = '0;
  logic [LN-1:0] in_lane_valid = '0;
  logic [LN*CW-1:0] in_num = '0;
  logic [LW-1:0] in_loc_base = '0;
  logic out_valid, out_hit, mn_valid, mn_hit;
  logic [XW-1:0] out_ctx, mn_ctx;
  logic [CW-1:0] out_max, mn_max;
  logic [LW-1:0] out_loc, mn_loc;
  int tests = 0, failed = 0;
  typedef struct {
    bit            v;
    logic [XW-1:0] ctx;
    logic [CW-1:0] mx;
    logic [LW-1:0] loc;
    bit            hit;
  } res_t;
  res_t pa, pb, held, none;
  int qv [CTX][$];
  logic [LW-1:0] ql [CTX][$];
  always #5 clk = ~clk;
  cmp_max_nway dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ctx(in_ctx),
    .in_first(in_first), .in_last(in_last), .in_lane_valid(in_lane_valid), .in_num(in_num),
    .in_loc_base(in_loc_base), .out_valid(out_valid), .out_ctx(out_ctx), .out_max(out_max),
    .out_loc(out_loc), .out_hit(out_hit)
  );
  cmp_max_nway #(.MODE_MIN(1)) u_min (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ctx(in_ctx),
    .in_first(in_first), .in_last(in_last), .in_lane_valid(in_lane_valid), .in_num(in_num),
    .in_loc_base(in_loc_base), .out_valid(mn_valid), .out_ctx(mn_ctx), .out_max(mn_max),
    .out_loc(mn_loc), .out_hit(mn_hit)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < CTX; k++) begin
      qv[k].delete();
      ql[k].delete();
    end
    pa = none;
    pb = none;
    held = none;
  endtask
  // Result of a finished search: first strictly-largest candidate in arrival order.
  function automatic res_t search(input int c);
    res_t r;
    int best;
    r = '{v: 1'b1, ctx: XW'(c), mx: 16'h8000, loc: '0, hit: 1'b0};
    best = 0;
    for (int k = 0; k < qv[c].size(); k++)
      if (!r.hit || qv[c][k] > best) begin
        best = qv[c][k];
        r.loc = ql[c][k];
        r.hit = 1'b1;
      end
    if (r.hit) r.mx = CW'(best);
    return r;
  endfunction
  task automatic step(input logic v, input int c, input logic f, input logic l, input logic [LN-1:0] lv,
                      input logic [LN*CW-1:0] n, input logic [LW-1:0] base, input logic clr);
    res_t nr;
    nr = none;
    in_valid = v; in_ctx = XW'(c); in_first = f; in_last = l;
    in_lane_valid = lv; in_num = n; in_loc_base = base; clear = clr;
    if (clr) begin
      for (int k = 0; k < CTX; k++) begin
        qv[k].delete();
        ql[k].delete();
      end
    end else if (v && c < CTX) begin
      if (f) begin
        qv[c].delete();
        ql[c].delete();
      end
      for (int i = 0; i < LN; i++)
        if (lv[i]) begin
          qv[c].push_back(int'($signed(n[i*CW +: CW])));
          ql[c].push_back(base + LW'(i));
        end
      if (l) begin
        nr = search(c);
        qv[c].delete();
        ql[c].delete();
      end
    end
    @(posedge clk);
    #1;
    if (pb.v) held = pb;
    chk("out_valid", 64'(out_valid), 64'(pb.v));
    chk("out_ctx", 64'(out_ctx), 64'(held.ctx));
    chk("out_max", 64'(out_max), 64'(held.mx));
    chk("out_loc", 64'(out_loc), 64'(held.loc));
    chk("out_hit", 64'(out_hit), 64'(held.hit));
    pb = clr ? none : pa;
    pa = nr;
  endtask
  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_ctx"}, 64'(out_ctx), 64'(0));
    chk({tag, "_max"}, 64'(out_max), 64'(0));
    chk({tag, "_loc"}, 64'(out_loc), 64'(0));
    chk({tag, "_hit"}, 64'(out_hit), 64'(0));
    chk({tag, "_min_valid"}, 64'(mn_valid), 64'(0));
    chk({tag, "_min_max"}, 64'(mn_max), 64'(0));
    chk({tag, "_min_loc"}, 64'(mn_loc), 64'(0));
    chk({tag, "_min_hit"}, 64'(mn_hit), 64'(0));
    chk({tag, "_min_ctx"}, 64'(mn_ctx), 64'(0));
  endtask
  function automatic logic [CW-1:0] rnd_val();
    int s;
    s = $urandom_range(0, 3);
    return s == 0 ? CW'($urandom) : s == 1 ? (($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF)
                                           : CW'($urandom_range(0, 6)) - 16'd3;
  endfunction
  initial begin
    none = '{v: 1'b0, ctx: '0, mx: '0, loc: '0, hit: 1'b0};
    model_reset();
    #4;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // Single-beat search, tie between lanes 2 and 3.
    step(1'b1, 0, 1'b1, 1'b1, 4'hF, {16'd9, 16'd9, 16'hFFFD, 16'd5}, 32'd100, 1'b0);
    idle(); idle();
    chk("r026_max", 64'(out_max), 64'd9);
    chk("r026_loc", 64'(out_loc), 64'd102);
    chk("r026_hit", 64'(out_hit), 64'd1);
    // Two consecutive beats, equal value keeps the earlier location.
    step(1'b1, 2, 1'b1, 1'b0, 4'hF, {16'd4, 16'd3, 16'd2, 16'd1}, 32'd0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b1, 4'hF, {16'd0, 16'd0, 16'd0, 16'd4}, 32'd8, 1'b0);
    idle(); idle();
    chk("r027_max", 64'(out_max), 64'd4);
    chk("r027_loc", 64'(out_loc), 64'd3);
    chk("r027_ctx", 64'(out_ctx), 64'd2);
    // Interleaved contexts every cycle.
    step(1'b1, 0, 1'b1, 1'b0, 4'hF, {16'hFFEC, 16'hFFF6, 16'hFFF8, 16'hFFF7}, 32'd10, 1'b0);
    step(1'b1, 1, 1'b1, 1'b0, 4'hF, {16'd0, 16'd3, 16'd12, 16'd1}, 32'd5, 1'b0);
    step(1'b1, 0, 1'b0, 1'b1, 4'hF, {16'hFF9C, 16'hFFF7, 16'hFFF9, 16'hFFE2}, 32'd40, 1'b0);
    step(1'b1, 1, 1'b0, 1'b1, 4'hF, {16'd5, 16'd5, 16'd5, 16'd12}, 32'd20, 1'b0);
    idle();
    chk("r028_ctx0_max", 64'(out_max), 64'hFFF9);
    chk("r028_ctx0_loc", 64'(out_loc), 64'd41);
    idle();
    chk("r028_ctx1_max", 64'(out_max), 64'd12);
    chk("r028_ctx1_loc", 64'(out_loc), 64'd6);
    // No valid lanes at all.
    step(1'b1, 3, 1'b1, 1'b1, 4'h0, {16'd1, 16'd2, 16'd3, 16'd4}, 32'd77, 1'b0);
    idle(); idle();
    chk("r029_hit", 64'(out_hit), 64'd0);
    chk("r029_max", 64'(out_max), 64'h8000);
    chk("r029_loc", 64'(out_loc), 64'd0);
    // Location wraps modulo 2^32.
    step(1'b1, 5, 1'b1, 1'b1, 4'hF, {16'd4, 16'd3, 16'd2, 16'd1}, 32'hFFFF_FFFE, 1'b0);
    idle(); idle();
    chk("wrap_loc", 64'(out_loc), 64'd1);
    // Clear right after a last beat; later search without first starts empty.
    step(1'b1, 4, 1'b1, 1'b0, 4'hF, {16'd1000, 16'd1000, 16'd1000, 16'd1000}, 32'd0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b1, 4'hF, {16'd4, 16'd3, 16'd2, 16'd1}, 32'd0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle();
    chk("r030_killed", 64'(out_valid), 64'd0);
    idle();
    step(1'b1, 4, 1'b0, 1'b1, 4'hF, {16'd3, 16'd3, 16'd3, 16'd3}, 32'd50, 1'b0);
    idle(); idle();
    chk("r030_max", 64'(out_max), 64'd3);
    chk("r030_loc", 64'(out_loc), 64'd50);
    // Minimum mode with duplicated most-negative values.
    step(1'b1, 0, 1'b1, 1'b1, 4'hF, {16'h8000, 16'd7, 16'h8000, 16'hFFFE}, 32'd0, 1'b0);
    idle(); idle();
    chk("r031_min_valid", 64'(mn_valid), 64'd1);
    chk("r031_min_max", 64'(mn_max), 64'h8000);
    chk("r031_min_loc", 64'(mn_loc), 64'd1);
    chk("r031_min_hit", 64'(mn_hit), 64'd1);
    // Reset while a last beat is in flight.
    step(1'b1, 1, 1'b1, 1'b0, 4'hF, {16'd90, 16'd91, 16'd92, 16'd93}, 32'd200, 1'b0);
    step(1'b1, 1, 1'b0, 1'b1, 4'hF, {16'd1, 16'd1, 16'd1, 16'd1}, 32'd210, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(); idle();
    step(1'b1, 1, 1'b0, 1'b1, 4'hF, {16'd8, 16'd7, 16'd6, 16'd5}, 32'd300, 1'b0);
    idle(); idle();
    chk("r023_max", 64'(out_max), 64'd8);
    chk("r023_loc", 64'(out_loc), 64'd303);
    // Random traffic, including out-of-range contexts and occasional clears.
    for (int n = 0; n < 600; n++) begin
      logic [LN*CW-1:0] nums;
      for (int i = 0; i < LN; i++) nums[i*CW +: CW] = rnd_val();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, LN'($urandom), nums, $urandom, $urandom_range(0, 49) == 0);
    end
    idle(); idle(); idle();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/cmp_max_nway.md
CMP_MAX_NWAY -- requirements
Module: cmp_max_nway

Interface
REQ-001 The block SHALL have parameter CMP_WIDTH, default 16, signed compare width.
REQ-002 The block SHALL have parameter LOCATION_WIDTH, default 32, location width.
REQ-003 The block SHALL have parameter LANES, default 4, candidates per beat (power of two, 1..16).
REQ-004 The block SHALL have parameter CTX, default 6, independent search contexts (2..64).
REQ-005 The block SHALL have parameter MODE_MIN, default 0; 1 selects minimum search.
REQ-006 The block SHALL have these ports, with CTX_W = clog2(CTX):
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush of all contexts and in-flight beats.
- in_valid  input  1  beat present.
- in_ctx  input  CTX_W  context index of beat.
- in_first  input  1  beat starts a new search in in_ctx.
- in_last  input  1  beat ends the search; result emitted.
- in_lane_valid  input  LANES  per-lane qualifier.
- in_num  input  LANES*CMP_WIDTH  signed candidates, lane 0 in LSBs.
- in_loc_base  input  LOCATION_WIDTH  location of lane 0; lane i = base+i, modulo 2^LOCATION_WIDTH.
- out_valid  output  1  one-cycle result pulse.
- out_ctx  output  CTX_W  context of result.
- out_max  output  CMP_WIDTH  winning value (minimum when MODE_MIN=1).
- out_loc  output  LOCATION_WIDTH  location of winner.
- out_hit  output  1  at least one valid lane seen in the search.

Function
REQ-007 Stage 1 SHALL reduce the valid lanes of a beat to one (value, location, any-valid) triple, registered.
REQ-008 Reduction ties SHALL resolve to the lower lane index.
REQ-009 Stage 2 SHALL merge the stage-1 triple into the context store entry for in_ctx, registered.
REQ-010 Merge SHALL replace the stored entry only on strictly greater (MODE_MIN=1: strictly less) value; equal values SHALL keep the earlier location.
REQ-011 A beat with in_first=1 SHALL discard the stored entry and take the beat's triple as the initial value.
REQ-012 A beat with no valid lanes SHALL leave the entry unchanged (with in_first=1: entry becomes empty).
REQ-013 An empty entry SHALL hold value MOST_NEG (MODE_MIN=1: MOST_POS), location 0, hit 0.
REQ-014 A beat with in_last=1 accepted at edge t SHALL produce out_valid=1 at edge t+2 carrying the merged result, including that beat.
REQ-015 After in_last the context entry SHALL become empty.
REQ-016 Back-to-back beats to the same context SHALL merge correctly via stage-2 forwarding; no input stall exists, full rate each cycle.
REQ-017 in_first and in_last both set SHALL yield a single-beat search result.
REQ-018 Beats with in_ctx >= CTX SHALL be dropped without output.
REQ-019 clear=1 at edge t SHALL empty all contexts, kill both pipeline stages and discard the beat presented at t; out_valid SHALL be 0 at t+1 and t+2 for killed beats.
REQ-020 out_* SHALL hold the last values between pulses; only out_valid pulses.
REQ-021 Signed comparison SHALL be used throughout; no arithmetic beyond location addition.

Reset
REQ-022 rst_n low SHALL asynchronously set out_valid, out_hit, out_ctx, out_max, out_loc to 0, empty every context and clear pipeline valids.
REQ-023 Deassertion mid-stream SHALL treat the first beat for each context as if in_first were set.

Structure
REQ-024 Package cmp_max_pkg SHALL hold MOST_NEG/MOST_POS constant functions of width, the better-than compare function with MODE select, and the context-entry struct (value, location, hit).
REQ-025 The lane reduction SHALL be sub-module cmp_max_lane_tree (combinational tree, LANES parameter).

Verification
REQ-026 LANES=4, ctx 0, first+last, nums {5,-3,9,9}, base 100 -> out_max 9, out_loc 102, out_hit 1 two cycles later.
REQ-027 ctx 2 beats consecutive: {1,2,3,4}@0 first, {4,0,0,0}@8 last -> out_max 4, out_loc 3 (tie keeps earlier).
REQ-028 Interleaved ctx 0,1,0,1 each cycle, ctx0 max -7 at loc 41, ctx1 max 12 at loc 6 -> two results, correct per context, forwarding exercised.
REQ-029 Search with all in_lane_valid=0, first+last -> out_hit 0, out_max 16'sh8000, out_loc 0.
REQ-030 clear asserted one cycle after a last beat -> no out_valid; next search with no in_first starts from empty.
REQ-031 MODE_MIN=1, nums {-2,-32768,7,-32768} base 0 -> out_max -32768, out_loc 1; rst_n pulse mid-search -> outputs 0, no stale result.
